// File: rtl/alt_s1_pkg.sv
// Shared definitions for the s1-calculator initiator: default widths,
// controller state encoding and the per-window snapshot record.
package alt_s1_pkg;

  localparam int NV_W_DEF    = 21;
  localparam int NU_W_DEF    = 25;
  localparam int NO_W_DEF    = 21;
  localparam int S1_W_DEF    = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int DROP_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Closed-window record at the default widths: three counts plus the
  // "some counter saturated" flag.
  typedef struct packed {
    logic [NV_W_DEF-1:0] nv;
    logic [NU_W_DEF-1:0] nu;
    logic [NO_W_DEF-1:0] no;
    logic                sat;
  } snap_t;

endpackage

// File: rtl/alt_sat_cnt.sv
// Saturating event counter for one detection class. The count output is the
// window total including the current cycle's event, so a window closed in the
// same cycle as an event still sees it.
module alt_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat_hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max_s;

  assign at_max_s = &cnt_q;
  assign sat_hit  = inc & at_max_s;

  // Window total including this cycle's event, pinned at all-ones once full.
  always_comb begin
    if (inc && !at_max_s) begin
      count = cnt_q + W'(1);
    end else begin
      count = cnt_q;
    end
  end

  // A closing window restarts the count at zero on the next cycle.
  always_comb begin
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else begin
      cnt_d = count;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alt_s1_ctrl.sv
// Initiator side of the s1-calculator handshake. Counts v/u/o events per
// block window, queues closed windows (one snapshot plus one pending slot),
// launches the calculator and reports one result strobe per launched window.
module alt_s1_ctrl
  import alt_s1_pkg::*;
#(
  parameter int NV_W        = NV_W_DEF,
  parameter int NU_W        = NU_W_DEF,
  parameter int NO_W        = NO_W_DEF,
  parameter int S1_W        = S1_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int DROP_W      = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_evt_v,
  input  logic              i_evt_u,
  input  logic              i_evt_o,
  input  logic              i_blk_end,
  output logic [NV_W-1:0]   o_nv,
  output logic [NU_W-1:0]   o_nu,
  output logic [NO_W-1:0]   o_no,
  output logic              o_start,
  input  logic [S1_W-1:0]   i_s1,
  input  logic              i_s1_vld,
  input  logic              i_s1_error,
  output logic [S1_W-1:0]   o_res,
  output logic              o_res_vld,
  output logic              o_res_err,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  // Same shape as snap_t, sized to this instance's counter widths.
  typedef struct packed {
    logic [NV_W-1:0] nv;
    logic [NU_W-1:0] nu;
    logic [NO_W-1:0] no;
    logic            sat;
  } win_t;

  logic [NV_W-1:0] cnt_v_s;
  logic [NU_W-1:0] cnt_u_s;
  logic [NO_W-1:0] cnt_o_s;
  logic            hit_v_s, hit_u_s, hit_o_s;
  logic            win_sat_s;
  win_t            win_s;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               sat_q, sat_d;
  win_t               snap_q, snap_d;
  logic               snap_vld_q, snap_vld_d;
  win_t               pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [NV_W-1:0]    nv_q, nv_d;
  logic [NU_W-1:0]    nu_q, nu_d;
  logic [NO_W-1:0]    no_q, no_d;
  logic               start_q, start_d;
  logic [S1_W-1:0]    res_q, res_d;
  logic               res_vld_q, res_vld_d;
  logic               res_err_q, res_err_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  alt_sat_cnt #(.W(NV_W)) u_cnt_v (
    .clk(clk), .rst(rst), .inc(i_evt_v), .clr(i_blk_end),
    .count(cnt_v_s), .sat_hit(hit_v_s)
  );
  alt_sat_cnt #(.W(NU_W)) u_cnt_u (
    .clk(clk), .rst(rst), .inc(i_evt_u), .clr(i_blk_end),
    .count(cnt_u_s), .sat_hit(hit_u_s)
  );
  alt_sat_cnt #(.W(NO_W)) u_cnt_o (
    .clk(clk), .rst(rst), .inc(i_evt_o), .clr(i_blk_end),
    .count(cnt_o_s), .sat_hit(hit_o_s)
  );

  // The closing window's sat flag includes a saturation hit in its last cycle.
  assign win_sat_s = sat_q | hit_v_s | hit_u_s | hit_o_s;
  assign win_s     = '{nv: cnt_v_s, nu: cnt_u_s, no: cnt_o_s, sat: win_sat_s};
  assign sat_d     = i_blk_end ? 1'b0 : win_sat_s;

  // Handshake sequencing, window queueing and result capture.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = drop_q;
    nv_d       = nv_q;
    nu_d       = nu_q;
    no_d       = no_q;
    start_d    = 1'b0;
    res_d      = res_q;
    res_vld_d  = 1'b0;
    res_err_d  = res_err_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        if (snap_vld_q) begin
          // Outputs for the LAUNCH cycle are registered on entry to it.
          state_d = LAUNCH;
          start_d = 1'b1;
          nv_d    = snap_q.nv;
          nu_d    = snap_q.nu;
          no_d    = snap_q.no;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        timer_d = {TMR_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (i_s1_vld) begin
          // A response in the timeout cycle still wins.
          res_d     = i_s1;
          res_err_d = i_s1_error | snap_q.sat;
          timeout_d = 1'b0;
          res_vld_d = 1'b1;
          state_d   = DONE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
          res_err_d = 1'b1;
          timeout_d = 1'b1;
          res_vld_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        snap_d     = pend_q;
        snap_vld_d = pend_vld_q;
        pend_vld_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A closing window sees the slots as freed by DONE in the same cycle.
    if (i_blk_end) begin
      if (!snap_vld_d) begin
        snap_d     = win_s;
        snap_vld_d = 1'b1;
      end else if (!pend_vld_d) begin
        pend_d     = win_s;
        pend_vld_d = 1'b1;
      end else if (!(&drop_q)) begin
        drop_d = drop_q + DROP_W'(1);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      drop_d = drop_q;
    end

    busy_d = (state_d != IDLE) | snap_vld_d | pend_vld_d;
  end

  // State, queue slots and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= {TMR_W{1'b0}};
      sat_q      <= 1'b0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      drop_q     <= {DROP_W{1'b0}};
      nv_q       <= {NV_W{1'b0}};
      nu_q       <= {NU_W{1'b0}};
      no_q       <= {NO_W{1'b0}};
      start_q    <= 1'b0;
      res_q      <= {S1_W{1'b0}};
      res_vld_q  <= 1'b0;
      res_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sat_q      <= sat_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
      nv_q       <= nv_d;
      nu_q       <= nu_d;
      no_q       <= no_d;
      start_q    <= start_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
      res_err_q  <= res_err_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign o_nv       = nv_q;
  assign o_nu       = nu_q;
  assign o_no       = no_q;
  assign o_start    = start_q;
  assign o_res      = res_q;
  assign o_res_vld  = res_vld_q;
  assign o_res_err  = res_err_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_alt_s1_ctrl.sv
// Bench for alt_s1_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model (window queue of
// depth two, launch/response timing from the handshake rules).
module tb_alt_s1_ctrl;

  localparam int NV_W        = 4;
  localparam int NU_W        = 25;
  localparam int NO_W        = 21;
  localparam int S1_W        = 32;
  localparam int TIMEOUT_CYC = 64;
  localparam int DROP_W      = 8;
  localparam int NV_MAX      = (1 << NV_W) - 1;
  localparam int NU_MAX      = (1 << NU_W) - 1;
  localparam int NO_MAX      = (1 << NO_W) - 1;
  localparam int DROP_MAX    = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_evt_v = 1'b0, i_evt_u = 1'b0, i_evt_o = 1'b0;
  logic              i_blk_end = 1'b0;
  logic [NV_W-1:0]   o_nv;
  logic [NU_W-1:0]   o_nu;
  logic [NO_W-1:0]   o_no;
  logic              o_start;
  logic [S1_W-1:0]   i_s1 = '0;
  logic              i_s1_vld = 1'b0;
  logic              i_s1_error = 1'b0;
  logic [S1_W-1:0]   o_res;
  logic              o_res_vld, o_res_err, o_timeout, o_busy;
  logic [DROP_W-1:0] o_drop_cnt;

  alt_s1_ctrl #(
    .NV_W(NV_W), .NU_W(NU_W), .NO_W(NO_W), .S1_W(S1_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_evt_v(i_evt_v), .i_evt_u(i_evt_u), .i_evt_o(i_evt_o),
    .i_blk_end(i_blk_end),
    .o_nv(o_nv), .o_nu(o_nu), .o_no(o_no), .o_start(o_start),
    .i_s1(i_s1), .i_s1_vld(i_s1_vld), .i_s1_error(i_s1_error),
    .o_res(o_res), .o_res_vld(o_res_vld), .o_res_err(o_res_err),
    .o_timeout(o_timeout), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    int nv;
    int nu;
    int no;
    bit sat;
    int arr;
  } win_t;

  win_t        wq[$];
  int          cv = 0, cu = 0, co = 0;
  int          free_edge = 0, start_edge = 0, done_at = 0;
  bit          active = 1'b0, done_flag = 1'b0;
  int          drop_m = 0;
  int          exp_nv = 0, exp_nu = 0, exp_no = 0;
  logic [31:0] exp_res = '0;
  bit          exp_start = 1'b0, exp_vld = 1'b0, exp_err = 1'b0, exp_to = 1'b0;

  // responder controls
  int          resp_edge = -1, resp_lat = -1;
  logic [31:0] resp_val = '0;
  bit          resp_err = 1'b0;
  bit          rand_lat = 1'b0, spur_en = 1'b0, force_vld = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int waited;
  bit seen;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int sat_to(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  // Advance the model by one clock edge with the inputs sampled there.
  task automatic model_edge(input int n, input bit ev, input bit eu, input bit eo,
                            input bit be, input bit r, input bit vld,
                            input logic [31:0] s1, input bit err);
    win_t w;
    int   lim;
    exp_start = 1'b0;
    exp_vld   = 1'b0;
    if (r) begin
      wq.delete();
      cv = 0; cu = 0; co = 0;
      active = 1'b0; done_flag = 1'b0; free_edge = n; drop_m = 0;
      exp_nv = 0; exp_nu = 0; exp_no = 0; exp_res = '0;
      exp_err = 1'b0; exp_to = 1'b0; resp_edge = -1;
    end else begin
      cv += int'(ev); cu += int'(eu); co += int'(eo);
      // result of the window in flight
      if (active && !done_flag) begin
        if (n >= start_edge + 2 && vld) begin
          done_flag = 1'b1; done_at = n; exp_vld = 1'b1;
          exp_res = s1; exp_err = err | wq[0].sat; exp_to = 1'b0;
        end else if (n == start_edge + TIMEOUT_CYC + 2) begin
          done_flag = 1'b1; done_at = n; exp_vld = 1'b1;
          exp_err = 1'b1; exp_to = 1'b1;
        end
      end
      // the slot is released at the end of the result cycle
      if (done_flag && n == done_at + 1) begin
        void'(wq.pop_front());
        active = 1'b0; done_flag = 1'b0; free_edge = n;
      end
      // window close
      if (be) begin
        w.nv  = sat_to(cv, NV_MAX);
        w.nu  = sat_to(cu, NU_MAX);
        w.no  = sat_to(co, NO_MAX);
        w.sat = (cv > NV_MAX) || (cu > NU_MAX) || (co > NO_MAX);
        w.arr = n;
        cv = 0; cu = 0; co = 0;
        if (wq.size() < 2) wq.push_back(w);
        else if (drop_m < DROP_MAX) drop_m++;
      end
      // launch one edge after both the window and the controller are ready
      if (!active && wq.size() > 0) begin
        lim = (wq[0].arr > free_edge) ? wq[0].arr : free_edge;
        if (n >= lim + 1) begin
          active = 1'b1; start_edge = n; exp_start = 1'b1;
          exp_nv = wq[0].nv; exp_nu = wq[0].nu; exp_no = wq[0].no;
          if (rand_lat) begin
            resp_lat = int'($urandom_range(0, 80));
            resp_val = $urandom;
            resp_err = 1'($urandom_range(0, 1));
          end
          resp_edge = (resp_lat < 0) ? -1 : n + resp_lat;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("start",   64'(o_start),   64'(exp_start));
    check_eq("nv",      64'(o_nv),      64'(exp_nv));
    check_eq("nu",      64'(o_nu),      64'(exp_nu));
    check_eq("no",      64'(o_no),      64'(exp_no));
    check_eq("res",     64'(o_res),     64'(exp_res));
    check_eq("res_vld", 64'(o_res_vld), 64'(exp_vld));
    check_eq("busy",    64'(o_busy),    64'(wq.size() > 0));
    check_eq("drop",    64'(o_drop_cnt), 64'(drop_m));
    if (exp_vld) begin
      check_eq("res_err", 64'(o_res_err), 64'(exp_err));
      check_eq("timeout", 64'(o_timeout), 64'(exp_to));
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare 1 time unit later.
  task automatic step(input bit ev, input bit eu, input bit eo, input bit be, input bit r);
    bit vld_s;
    i_evt_v   = ev;
    i_evt_u   = eu;
    i_evt_o   = eo;
    i_blk_end = be;
    rst       = r;
    vld_s     = force_vld || (cyc == resp_edge) || (spur_en && $urandom_range(0, 29) == 0);
    i_s1_vld  = vld_s;
    i_s1      = (cyc == resp_edge) ? resp_val : $urandom;
    i_s1_error = (cyc == resp_edge) ? resp_err : 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(cyc, ev, eu, eo, be, r, vld_s, i_s1, i_s1_error);
    #1;
    compare_outputs();
    cyc++;
  endtask

  task automatic pulses(input int nv, input int nu, input int no);
    int mx;
    mx = (nv > nu) ? nv : nu;
    mx = (mx > no) ? mx : no;
    for (int i = 0; i < mx; i++) step(i < nv, i < nu, i < no, 1'b0, 1'b0);
  endtask

  task automatic wait_res(input int budget, output int n_wait);
    n_wait = 0;
    while (!o_res_vld && n_wait < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_wait++;
    end
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check_eq("rst_start", 64'(o_start), 64'd0);
    check_eq("rst_busy",  64'(o_busy),  64'd0);
    check_eq("rst_res",   64'(o_res),   64'd0);
    check_eq("rst_drop",  64'(o_drop_cnt), 64'd0);

    // basic block: 10 v, 20 u, 5 o, response 6 cycles after start
    resp_lat = 6; resp_val = 32'h0000_1234; resp_err = 1'b0;
    pulses(10, 20, 5);
    step(0, 0, 0, 1, 0);
    check_eq("basic_t1_start", 64'(o_start), 64'd0);
    step(0, 0, 0, 0, 0);
    check_eq("basic_t2_start", 64'(o_start), 64'd1);
    check_eq("basic_nv", 64'(o_nv), 64'd10);
    check_eq("basic_nu", 64'(o_nu), 64'd20);
    check_eq("basic_no", 64'(o_no), 64'd5);
    repeat (6) step(0, 0, 0, 0, 0);
    check_eq("basic_vld", 64'(o_res_vld), 64'd1);
    check_eq("basic_res", 64'(o_res), 64'h1234);
    check_eq("basic_err", 64'(o_res_err), 64'd0);
    check_eq("basic_to",  64'(o_timeout), 64'd0);
    step(0, 0, 0, 0, 0);
    check_eq("basic_vld_pulse", 64'(o_res_vld), 64'd0);
    repeat (3) step(0, 0, 0, 0, 0);

    // calculator error
    resp_lat = 4; resp_val = 32'h0000_BEEF; resp_err = 1'b1;
    pulses(3, 3, 3);
    step(0, 0, 0, 1, 0);
    wait_res(20, waited);
    check_eq("cerr_seen", 64'(o_res_vld), 64'd1);
    check_eq("cerr_err",  64'(o_res_err), 64'd1);
    check_eq("cerr_to",   64'(o_timeout), 64'd0);
    repeat (3) step(0, 0, 0, 0, 0);

    // timeout, then a late response that must be ignored
    resp_lat = -1; resp_err = 1'b0;
    pulses(2, 2, 2);
    step(0, 0, 0, 1, 0);
    wait_res(100, waited);
    check_eq("to_seen", 64'(o_res_vld), 64'd1);
    check_eq("to_lat",  64'(waited), 64'd67);
    check_eq("to_err",  64'(o_res_err), 64'd1);
    check_eq("to_flag", 64'(o_timeout), 64'd1);
    check_eq("to_res_hold", 64'(o_res), 64'hBEEF);
    step(0, 0, 0, 0, 0);
    force_vld = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    force_vld = 1'b0;
    check_eq("late_ignored", 64'(o_res_vld), 64'd0);
    check_eq("late_idle",    64'(o_busy),    64'd0);
    step(0, 0, 0, 0, 0);

    // back-to-back windows: one pending, one dropped
    resp_lat = 30; resp_val = 32'h5555_0001; resp_err = 1'b0;
    pulses(1, 1, 1);
    step(0, 0, 0, 1, 0);
    pulses(2, 0, 0);
    step(0, 0, 0, 1, 0);
    pulses(1, 0, 0);
    step(0, 0, 0, 1, 0);
    check_eq("b2b_drop", 64'(o_drop_cnt), 64'd1);
    wait_res(60, waited);
    check_eq("b2b_first_seen", 64'(o_res_vld), 64'd1);
    step(0, 0, 0, 0, 0);
    check_eq("b2b_gap", 64'(o_start), 64'd0);
    step(0, 0, 0, 0, 0);
    check_eq("b2b_launch", 64'(o_start), 64'd1);
    check_eq("b2b_nv", 64'(o_nv), 64'd2);
    check_eq("b2b_nu", 64'(o_nu), 64'd0);
    wait_res(60, waited);
    check_eq("b2b_second_seen", 64'(o_res_vld), 64'd1);
    repeat (3) step(0, 0, 0, 0, 0);

    // saturation of the 4-bit v counter; u event on the closing cycle
    resp_lat = 3; resp_err = 1'b0;
    pulses(20, 7, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check_eq("sat_nv", 64'(o_nv), 64'd15);
    check_eq("sat_nu_edge", 64'(o_nu), 64'd8);
    wait_res(20, waited);
    check_eq("sat_err", 64'(o_res_err), 64'd1);
    check_eq("sat_to",  64'(o_timeout), 64'd0);
    repeat (2) step(0, 0, 0, 0, 0);
    pulses(3, 2, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check_eq("next_win_nv", 64'(o_nv), 64'd3);
    check_eq("next_win_nu", 64'(o_nu), 64'd2);
    wait_res(20, waited);
    check_eq("next_win_err", 64'(o_res_err), 64'd0);
    repeat (2) step(0, 0, 0, 0, 0);

    // reset while waiting
    resp_lat = -1;
    pulses(1, 1, 1);
    step(0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check_eq("rstw_busy", 64'(o_busy), 64'd0);
    check_eq("rstw_nv",   64'(o_nv),   64'd0);
    check_eq("rstw_res",  64'(o_res),  64'd0);
    check_eq("rstw_drop", 64'(o_drop_cnt), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(0, 0, 0, 0, 0);
      seen = seen | o_res_vld;
    end
    check_eq("rstw_no_vld", 64'(seen), 64'd0);
    resp_lat = 5; resp_val = 32'hCAFE_0042; resp_err = 1'b0;
    pulses(4, 4, 4);
    step(0, 0, 0, 1, 0);
    wait_res(20, waited);
    check_eq("post_rst_seen", 64'(o_res_vld), 64'd1);
    check_eq("post_rst_lat",  64'(waited), 64'd6);
    check_eq("post_rst_res",  64'(o_res), 64'hCAFE_0042);
    repeat (3) step(0, 0, 0, 0, 0);

    // randomized traffic
    rand_lat = 1'b1; spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 599) == 0);
    end
    rand_lat = 1'b0; spur_en = 1'b0; resp_lat = -1;
    repeat (200) step(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_s1_ctrl.md
Name: alt_s1_ctrl

Overview:
- Initiator side of the s1-calculator handshake (start / vld / error).
- Counts per-class detection events (v, u, o) over a block window; the window is closed by i_blk_end.
- At each window close it snapshots the counts, drives the calculator's nv/nu/no inputs and start pulse, then waits for the result.
- Captures s1 and its error flag and reports a per-block result, with timeout and dropped-block accounting.

Parameters:
NV_W, 21, width of v-event counter / o_nv
NU_W, 25, width of u-event counter / o_nu
NO_W, 21, width of o-event counter / o_no
S1_W, 32, width of s1 result
TIMEOUT_CYC, 64, max WAIT cycles before declaring timeout (≥2)
DROP_W, 8, width of dropped-block counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_evt_v  in  1  one v-class event this cycle
i_evt_u  in  1  one u-class event this cycle
i_evt_o  in  1  one o-class event this cycle
i_blk_end  in  1  window close strobe
o_nv  out  NV_W  latched v count to calculator
o_nu  out  NU_W  latched u count to calculator
o_no  out  NO_W  latched o count to calculator
o_start  out  1  one-cycle start pulse to calculator
i_s1  in  S1_W  calculator result
i_s1_vld  in  1  calculator result valid
i_s1_error  in  1  calculator error flag (stable when i_s1_vld=1)
o_res  out  S1_W  captured s1
o_res_vld  out  1  one-cycle result strobe
o_res_err  out  1  calc error OR timeout OR saturation, qualified by o_res_vld
o_timeout  out  1  result was a timeout, qualified by o_res_vld
o_busy  out  1  state != IDLE or pending snapshot held
o_drop_cnt  out  DROP_W  saturating count of discarded windows

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, pending=0.
- Counting:
  - Each counter increments by 1 when its i_evt_* is high and saturates at all-ones.
  - A per-window sat flag is set if any counter would exceed its maximum.
  - An event coinciding with i_blk_end belongs to the closing window; counters and the sat flag read 0 the following cycle.
  - Counting never stops regardless of state.
- Snapshot: on i_blk_end, {counts, sat} are copied into the snapshot register when it is free, else into the pending register.
  - If pending is already full, the window is discarded and o_drop_cnt increments (saturating).
- FSM:
  - IDLE: snapshot valid → LAUNCH.
  - LAUNCH (1 cycle): o_nv/o_nu/o_no <= snapshot; o_start=1; timer cleared → WAIT.
  - i_blk_end sampled in IDLE at cycle T gives o_start high at T+2. o_nv/o_nu/o_no become valid at T+2 and hold until the next LAUNCH.
  - WAIT: on i_s1_vld → capture o_res <= i_s1; o_res_err <= i_s1_error | sat; o_timeout <= 0; go to DONE.
  - WAIT timeout: if the timer reaches TIMEOUT_CYC first → o_res holds its old value; o_res_err=1; o_timeout=1; go to DONE.
  - DONE (1 cycle): o_res_vld=1; the snapshot is freed and pending moves into it → IDLE. If a snapshot is valid, LAUNCH follows directly after that IDLE cycle.
- i_s1_vld outside WAIT is ignored, including a late response arriving after a timeout.
- i_s1_vld and timeout in the same cycle: i_s1_vld wins.
- rst mid-operation: immediate return to the reset state. The snapshot and pending windows are lost and no o_res_vld is emitted.

Decomposition:
- Package alt_s1_pkg: NV_W/NU_W/NO_W/S1_W defaults, state encoding (IDLE, LAUNCH, WAIT, DONE), and a snapshot record {nv, nu, no, sat}.
- One sub-module, alt_sat_cnt (parameterized width, inc, clr, count, sat_hit), instantiated three times.

Test Plan:
- Basic block: 10 v, 20 u, 5 o pulses, then i_blk_end at T → o_nv=10, o_nu=20, o_no=5, o_start high at T+2 only. Then return i_s1=0x1234 with i_s1_vld 6 cycles later → o_res=0x1234, o_res_vld one cycle, o_res_err=0, o_timeout=0.
- Calculator error: same flow with i_s1_error=1 at i_s1_vld → o_res_err=1, o_timeout=0.
- Timeout: never assert i_s1_vld → o_res_vld exactly TIMEOUT_CYC(64)+1 cycles after WAIT entry with o_timeout=1, o_res_err=1. A later i_s1_vld is ignored.
- Back-to-back windows: i_blk_end during WAIT, then again during the same WAIT → first extra window pending and launched right after DONE+IDLE; second discarded, o_drop_cnt=1.
- Saturation / boundary: NV_W=4 build, 20 v pulses → o_nv=15 and o_res_err=1. An event on the same cycle as i_blk_end is counted in the closing window, and the next window starts at 0.
- Reset in WAIT: rst for 1 cycle → all outputs 0, no o_res_vld. A subsequent block runs normally.
